// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue/retire controller: operand register feeding an external combinational ALU,
// a response register toward writeback, and a held signed-overflow exception with a RUN/TRAP FSM.
package cpu_types_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_SRA  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_ADDU = 4'd4,
    ALU_SUB  = 4'd5,
    ALU_SUBU = 4'd6,
    ALU_AND  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_XOR  = 4'd9,
    ALU_NOR  = 4'd10,
    ALU_SLT  = 4'd11,
    ALU_SLTU = 4'd12
  } aluop_t;
endpackage

module alu_issue_ctrl
  import cpu_types_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  aluop_t            req_op,
  input  logic [WORD_W-1:0] req_a,
  input  logic [WORD_W-1:0] req_b,
  input  logic [4:0]        req_shamt,
  input  logic              req_use_shamt,
  input  logic              req_trap_ov,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [WORD_W-1:0] alu_port_a,
  output logic [WORD_W-1:0] alu_port_b,
  output aluop_t            alu_op,
  input  logic [WORD_W-1:0] alu_result,
  input  logic              alu_negative,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_negative,
  output logic              rsp_carry,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              exc_ov,
  output logic [TAG_W-1:0]  exc_tag,
  input  logic              exc_ack
);

  typedef enum logic {ST_RUN = 1'b0, ST_TRAP = 1'b1} state_t;

  state_t              state_q, state_d;

  logic                s1_valid_q, s1_valid_d;
  logic [WORD_W-1:0]   port_a_q, port_a_d;
  logic [WORD_W-1:0]   port_b_q, port_b_d;
  aluop_t              op_q, op_d;
  logic                s1_trap_q, s1_trap_d;
  logic [TAG_W-1:0]    s1_tag_q, s1_tag_d;

  logic                rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0]   rsp_result_q, rsp_result_d;
  logic                rsp_zero_q, rsp_zero_d;
  logic                rsp_negative_q, rsp_negative_d;
  logic                rsp_carry_q, rsp_carry_d;
  logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;

  logic                exc_ov_q, exc_ov_d;
  logic [TAG_W-1:0]    exc_tag_q, exc_tag_d;

  logic                s2_adv;
  logic                sov;
  logic                trap_fire;
  logic                s2_load;
  logic                req_hs;
  logic                a_sign, b_sign, r_sign;

  assign a_sign = port_a_q[WORD_W-1];
  assign b_sign = port_b_q[WORD_W-1];
  assign r_sign = alu_result[WORD_W-1];

  // Only signed ADD/SUB can raise the exception; the ALU carry flag is never consulted here.
  always_comb begin
    sov = 1'b0;
    if (op_q == ALU_ADD) begin
      sov = (a_sign == b_sign) && (r_sign != a_sign);
    end else if (op_q == ALU_SUB) begin
      sov = (a_sign != b_sign) && (r_sign != a_sign);
    end
  end

  assign s2_adv    = s1_valid_q && (!rsp_valid_q || rsp_ready);
  assign trap_fire = (state_q == ST_RUN) && s2_adv && s1_trap_q && sov;
  assign s2_load   = s2_adv && !trap_fire;
  assign req_hs    = req_valid && req_ready;

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (trap_fire) state_d = ST_TRAP;
      ST_TRAP: if (exc_ack)   state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // FSM: outputs. Intake also closes in the cycle the trap fires so no younger op slips in behind it.
  always_comb begin
    req_ready = 1'b0;
    case (state_q)
      ST_RUN:  req_ready = (!s1_valid_q || s2_adv) && !trap_fire;
      default: req_ready = 1'b0;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    port_a_d   = port_a_q;
    port_b_d   = port_b_q;
    op_d       = op_q;
    s1_trap_d  = s1_trap_q;
    s1_tag_d   = s1_tag_q;
    if (req_hs) begin
      s1_valid_d = 1'b1;
      port_a_d   = req_use_shamt ? {{(WORD_W-5){1'b0}}, req_shamt} : req_a;
      port_b_d   = req_b;
      op_d       = req_op;
      s1_trap_d  = req_trap_ov;
      s1_tag_d   = req_tag;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_negative_d = rsp_negative_q;
    rsp_carry_d    = rsp_carry_q;
    rsp_tag_d      = rsp_tag_q;
    if (s2_load) begin
      rsp_valid_d    = 1'b1;
      rsp_result_d   = alu_result;
      rsp_zero_d     = (alu_result == '0);
      rsp_negative_d = alu_negative;
      rsp_carry_d    = alu_overflow;
      rsp_tag_d      = s1_tag_q;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_comb begin
    exc_ov_d  = exc_ov_q;
    exc_tag_d = exc_tag_q;
    if (trap_fire) begin
      exc_ov_d  = 1'b1;
      exc_tag_d = s1_tag_q;
    end else if ((state_q == ST_TRAP) && exc_ack) begin
      exc_ov_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q     <= 1'b0;
      port_a_q       <= '0;
      port_b_q       <= '0;
      op_q           <= ALU_SLL;
      s1_trap_q      <= 1'b0;
      s1_tag_q       <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b1;
      rsp_negative_q <= 1'b0;
      rsp_carry_q    <= 1'b0;
      rsp_tag_q      <= '0;
      exc_ov_q       <= 1'b0;
      exc_tag_q      <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      port_a_q       <= port_a_d;
      port_b_q       <= port_b_d;
      op_q           <= op_d;
      s1_trap_q      <= s1_trap_d;
      s1_tag_q       <= s1_tag_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_negative_q <= rsp_negative_d;
      rsp_carry_q    <= rsp_carry_d;
      rsp_tag_q      <= rsp_tag_d;
      exc_ov_q       <= exc_ov_d;
      exc_tag_q      <= exc_tag_d;
    end
  end

  assign alu_port_a   = port_a_q;
  assign alu_port_b   = port_b_q;
  assign alu_op       = op_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_negative = rsp_negative_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_tag      = rsp_tag_q;
  assign exc_ov       = exc_ov_q;
  assign exc_tag      = exc_tag_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a behavioural ALU stub closes the loop, a negedge monitor
// predicts responses/exceptions at each accepted request and checks them as the DUT presents them.
module tb_alu_issue_ctrl;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  aluop_t      req_op = ALU_SLL;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_shamt = '0;
  logic        req_use_shamt = 1'b0;
  logic        req_trap_ov = 1'b0;
  logic [3:0]  req_tag = '0;
  logic [31:0] alu_port_a, alu_port_b;
  aluop_t      alu_op;
  logic [31:0] alu_result;
  logic        alu_negative, alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_negative, rsp_carry;
  logic [3:0]  rsp_tag;
  logic        exc_ov;
  logic [3:0]  exc_tag;
  logic        exc_ack = 1'b0;

  alu_issue_ctrl #(.TAG_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_shamt(req_shamt), .req_use_shamt(req_use_shamt), .req_trap_ov(req_trap_ov), .req_tag(req_tag),
    .alu_port_a(alu_port_a), .alu_port_b(alu_port_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_negative(alu_negative), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_negative(rsp_negative), .rsp_carry(rsp_carry), .rsp_tag(rsp_tag),
    .exc_ov(exc_ov), .exc_tag(exc_tag), .exc_ack(exc_ack)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ref_alu(input aluop_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_SLL:            return b << a[4:0];
      ALU_SRL:            return b >> a[4:0];
      ALU_SRA:            return $signed(b) >>> a[4:0];
      ALU_ADD, ALU_ADDU:  return a + b;
      ALU_SUB, ALU_SUBU:  return a - b;
      ALU_AND:            return a & b;
      ALU_OR:             return a | b;
      ALU_XOR:            return a ^ b;
      ALU_NOR:            return ~(a | b);
      ALU_SLT:            return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:           return {31'b0, a < b};
      default:            return 32'h0;
    endcase
  endfunction

  function automatic logic ref_carry(input aluop_t op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      ALU_ADD, ALU_ADDU: return s[32];
      ALU_SUB, ALU_SUBU: return a >= b;
      default:           return 1'b0;
    endcase
  endfunction

  // Signed overflow judged by whether the true integer result fits in 32-bit two's complement.
  function automatic logic ref_sov(input aluop_t op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == ALU_ADD)      s = sa + sb;
    else if (op == ALU_SUB) s = sa - sb;
    else                    return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  assign alu_result   = ref_alu(alu_op, alu_port_a, alu_port_b);
  assign alu_negative = alu_result[31];
  assign alu_overflow = ref_carry(alu_op, alu_port_a, alu_port_b);

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        neg;
    logic        carry;
    logic [3:0]  tag;
  } rsp_t;

  rsp_t       rsp_q[$];
  logic [3:0] exc_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         acc_cnt = 0;
  int         cyc = 0;
  bit         rand_rsp = 1'b0, rsp_force = 1'b1;
  bit         auto_ack = 1'b0, ack_force = 1'b0;

  task automatic chk(input bit ok, input string name, input string msg);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: %s", name, msg);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  initial forever begin
    @(posedge CLK);
    #2;
    rsp_ready = rand_rsp ? ($urandom_range(0, 3) != 0) : rsp_force;
    if (auto_ack) exc_ack = exc_ov ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
    else          exc_ack = ack_force;
  end

  // Monitor / scoreboard
  initial begin
    bit   prev_rst = 1'b1, prev_exc = 1'b0, prev_ack = 1'b0, exc_seen = 1'b0;
    rsp_t e;
    logic [31:0] a_eff;
    forever begin
      @(negedge CLK);
      if (RST) begin
        rsp_q.delete();
        exc_q.delete();
        exc_seen = 1'b0;
      end else begin
        if (!prev_rst && prev_exc) begin
          if (prev_ack) chk(exc_ov == 1'b0, "exc_clear_on_ack", $sformatf("exc_ov=%b want 0", exc_ov));
          else          chk(exc_ov == 1'b1, "exc_held", $sformatf("exc_ov=%b want 1", exc_ov));
        end
        if (req_valid && req_ready) begin
          acc_cnt++;
          a_eff = req_use_shamt ? {27'b0, req_shamt} : req_a;
          if (req_trap_ov && ref_sov(req_op, a_eff, req_b)) begin
            exc_q.push_back(req_tag);
          end else begin
            e.result = ref_alu(req_op, a_eff, req_b);
            e.zero   = (e.result == 32'h0);
            e.neg    = e.result[31];
            e.carry  = ref_carry(req_op, a_eff, req_b);
            e.tag    = req_tag;
            rsp_q.push_back(e);
          end
        end
        if (rsp_valid) begin
          if (rsp_q.size() == 0) begin
            chk(1'b0, "rsp_unexpected", $sformatf("got result=%h tag=%h, required no response", rsp_result, rsp_tag));
          end else begin
            e = rsp_q[0];
            chk(rsp_result == e.result && rsp_zero == e.zero && rsp_negative == e.neg &&
                rsp_carry == e.carry && rsp_tag == e.tag, "rsp_data",
                $sformatf("got res=%h z=%b n=%b c=%b tag=%h, required res=%h z=%b n=%b c=%b tag=%h",
                          rsp_result, rsp_zero, rsp_negative, rsp_carry, rsp_tag,
                          e.result, e.zero, e.neg, e.carry, e.tag));
            if (rsp_ready) begin
              void'(rsp_q.pop_front());
              $display("rsp  tag=%h result=%h z=%b n=%b c=%b", rsp_tag, rsp_result, rsp_zero, rsp_negative, rsp_carry);
            end
          end
        end
        if (exc_ov) begin
          chk(req_ready == 1'b0, "ready_during_trap", $sformatf("req_ready=%b want 0", req_ready));
          if (!exc_seen) begin
            if (exc_q.size() == 0) begin
              chk(1'b0, "exc_unexpected", $sformatf("got exc_tag=%h, required no exception", exc_tag));
            end else begin
              chk(exc_tag == exc_q[0], "exc_tag", $sformatf("got %h required %h", exc_tag, exc_q[0]));
              $display("exc  tag=%h", exc_tag);
              void'(exc_q.pop_front());
            end
          end
          exc_seen = 1'b1;
        end else begin
          exc_seen = 1'b0;
        end
      end
      prev_rst = RST;
      prev_exc = exc_ov;
      prev_ack = exc_ack;
    end
  end

  task automatic issue(input aluop_t op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                       input logic use_sh, input logic trap, input logic [3:0] tag);
    bit ok = 1'b0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    req_shamt = sh; req_use_shamt = use_sh; req_trap_ov = trap; req_tag = tag;
    for (int w = 0; w < 200; w++) begin
      @(negedge CLK);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk(1'b0, "issue_timeout", "req_ready stayed 0 for 200 cycles, required an accept");
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_exc();
    bit seen = 1'b0;
    for (int w = 0; w < 30; w++) begin
      @(negedge CLK);
      if (exc_ov) begin seen = 1'b1; break; end
    end
    chk(seen, "exc_timeout", $sformatf("exc_ov=%b after 30 cycles, required 1", exc_ov));
    @(posedge CLK);
    #1;
  endtask

  task automatic ack_once();
    ack_force = 1'b1;
    @(posedge CLK);
    #1;
    ack_force = 1'b0;
    idle(1);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int c0, a0;
    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk(rsp_valid == 0 && exc_ov == 0 && rsp_zero == 1 && rsp_result == 0 && rsp_tag == 0 &&
        exc_tag == 0 && rsp_negative == 0 && rsp_carry == 0 && alu_port_a == 0 && alu_port_b == 0 &&
        alu_op == ALU_SLL, "reset_state",
        $sformatf("got rv=%b ov=%b z=%b res=%h tag=%h etag=%h n=%b c=%b pa=%h pb=%h op=%0d, required z=1 rest 0",
                  rsp_valid, exc_ov, rsp_zero, rsp_result, rsp_tag, exc_tag, rsp_negative, rsp_carry,
                  alu_port_a, alu_port_b, alu_op));
    @(posedge CLK); #1;
    RST = 1'b0;
    idle(1);

    // 1: ADD latency
    issue(ALU_ADD, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0, 4'd3);
    @(negedge CLK);
    chk(rsp_valid == 1'b0, "latency_early", $sformatf("rsp_valid=%b one cycle after accept, required 0", rsp_valid));
    @(negedge CLK);
    chk(rsp_valid == 1'b1, "latency_2", $sformatf("rsp_valid=%b two cycles after accept, required 1", rsp_valid));
    idle(2);

    // 2: back-to-back without a bubble
    c0 = cyc;
    issue(ALU_SUB, 32'd10, 32'd10, 5'd0, 1'b0, 1'b0, 4'd4);
    issue(ALU_SLL, 32'd0, 32'd1, 5'd4, 1'b1, 1'b0, 4'd5);
    issue(ALU_OR, 32'hF0, 32'h0F, 5'd0, 1'b0, 1'b0, 4'd6);
    chk(cyc - c0 == 3, "b2b_throughput", $sformatf("3 ops took %0d cycles, required 3", cyc - c0));
    idle(4);

    // 3: downstream stall
    rsp_force = 1'b0;
    a0 = acc_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++) issue(ALU_XOR, $urandom, $urandom, 5'd0, 1'b0, 1'b0, 4'(i + 7));
      end
      begin
        repeat (4) @(negedge CLK);
        chk(req_ready == 1'b0 && acc_cnt - a0 == 2, "stall_backpressure",
            $sformatf("req_ready=%b accepted=%0d, required ready=0 accepted=2", req_ready, acc_cnt - a0));
        rsp_force = 1'b1;
      end
    join
    idle(4);

    // 4: trapping ADD, then the same op without trap
    issue(ALU_ADD, 32'h7FFFFFFF, 32'd1, 5'd0, 1'b0, 1'b1, 4'd9);
    wait_exc();
    idle(3);
    ack_once();
    issue(ALU_ADD, 32'h7FFFFFFF, 32'd1, 5'd0, 1'b0, 1'b0, 4'd10);
    // 5: carry only, no trap
    issue(ALU_ADD, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0, 1'b1, 4'd11);
    idle(4);
    chk(exc_ov == 1'b0, "carry_no_trap", $sformatf("exc_ov=%b required 0", exc_ov));

    // 6: older op stalled in stage 2 when the trap fires
    rsp_force = 1'b0;
    issue(ALU_ADD, 32'd1, 32'd2, 5'd0, 1'b0, 1'b0, 4'd1);
    issue(ALU_SUB, 32'h80000000, 32'd1, 5'd0, 1'b0, 1'b1, 4'd2);
    idle(3);
    rsp_force = 1'b1;
    wait_exc();
    ack_once();
    idle(2);

    // Reset mid-stream: in-flight ops, then a pending exception
    rsp_force = 1'b0;
    issue(ALU_AND, 32'hFF00, 32'h0FF0, 5'd0, 1'b0, 1'b0, 4'd12);
    issue(ALU_NOR, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 4'd13);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    @(negedge CLK);
    chk(rsp_valid == 1'b0 && exc_ov == 1'b0, "rst_flush_rsp", $sformatf("rsp_valid=%b exc_ov=%b, required 0 0", rsp_valid, exc_ov));
    rsp_force = 1'b1;
    idle(1);
    issue(ALU_ADD, 32'h80000000, 32'h80000000, 5'd0, 1'b0, 1'b1, 4'd14);
    wait_exc();
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    @(negedge CLK);
    chk(rsp_valid == 1'b0 && exc_ov == 1'b0, "rst_flush_exc", $sformatf("rsp_valid=%b exc_ov=%b, required 0 0", rsp_valid, exc_ov));
    idle(1);

    // Randomised stream
    rand_rsp = 1'b1;
    auto_ack = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      issue(aluop_t'($urandom_range(0, 12)), rand_word(), rand_word(), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    // Drain
    rand_rsp = 1'b0;
    rsp_force = 1'b1;
    for (int w = 0; w < 100; w++) begin
      @(negedge CLK);
      if (rsp_q.size() == 0 && exc_q.size() == 0 && !rsp_valid && !exc_ov) break;
    end
    chk(rsp_q.size() == 0 && exc_q.size() == 0, "drain_empty",
        $sformatf("pending rsp=%0d exc=%0d, required 0 0", rsp_q.size(), exc_q.size()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
